sys_ctrl: RTL and testbench

//  Command sequencer between the UART RX deserializer, the register file, the ALU and the TX FIFO.

---
 rtl/sys_ctrl_pkg.sv | 37 +++
 rtl/sys_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_sys_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sys_ctrl_pkg
//  Brief    : Shared constants for the system command sequencer: command
//             opcodes, FSM state encoding and reserved ALU operand addresses.
//  Revision : 1.0 - initial release
// ============================================================================
package sys_ctrl_pkg;

    // Framed command opcodes recognised in IDLE
    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    // Sequencer state encoding
    localparam int STATE_WIDTH = 4;
    localparam logic [STATE_WIDTH-1:0] ST_IDLE     = 4'd0;
    localparam logic [STATE_WIDTH-1:0] ST_WR_ADDR  = 4'd1;
    localparam logic [STATE_WIDTH-1:0] ST_WR_DATA  = 4'd2;
    localparam logic [STATE_WIDTH-1:0] ST_RD_ADDR  = 4'd3;
    localparam logic [STATE_WIDTH-1:0] ST_RD_WAIT  = 4'd4;
    localparam logic [STATE_WIDTH-1:0] ST_RD_TX    = 4'd5;
    localparam logic [STATE_WIDTH-1:0] ST_OPA      = 4'd6;
    localparam logic [STATE_WIDTH-1:0] ST_OPB      = 4'd7;
    localparam logic [STATE_WIDTH-1:0] ST_FUN      = 4'd8;
    localparam logic [STATE_WIDTH-1:0] ST_ALU_WAIT = 4'd9;
    localparam logic [STATE_WIDTH-1:0] ST_TX_LO    = 4'd10;
    localparam logic [STATE_WIDTH-1:0] ST_TX_HI    = 4'd11;

    // Register-file locations reserved for the ALU operands
    localparam logic [3:0] ADDR_OPA = 4'h0;
    localparam logic [3:0] ADDR_OPB = 4'h1;

endpackage
`default_nettype wire

// File: rtl/sys_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sys_ctrl
//  Brief    : Command sequencer between UART RX, register file, ALU and TX
//             FIFO. Parses framed byte commands, issues register writes and
//             reads, launches ALU operations and returns results to TX.
//  Revision : 1.0 - initial release
// ============================================================================
module sys_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_OUT_WIDTH = 16,
    parameter int FUN_WIDTH     = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]    RdData,
    input  logic                     RdData_Valid,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     OUT_Valid,
    input  logic                     FIFO_FULL,
    output logic [ADDR_WIDTH-1:0]    Address,
    output logic [DATA_WIDTH-1:0]    WrData,
    output logic                     WrEn,
    output logic                     RdEn,
    output logic [FUN_WIDTH-1:0]     ALU_FUN,
    output logic                     ALU_EN,
    output logic                     CLK_EN,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     TX_D_VLD
);

    logic [STATE_WIDTH-1:0]   state;
    logic [STATE_WIDTH-1:0]   next_state;

    // Captured read data and ALU result, held until pushed to TX
    logic [DATA_WIDTH-1:0]    rd_capture;
    logic [ALU_OUT_WIDTH-1:0] alu_result;

    // Next values of the registered outputs
    logic [ADDR_WIDTH-1:0]    next_address;
    logic [DATA_WIDTH-1:0]    next_wr_data;
    logic                     next_wr_en;
    logic                     next_rd_en;
    logic [FUN_WIDTH-1:0]     next_alu_fun;
    logic                     next_alu_en;
    logic                     next_clk_en;
    logic [DATA_WIDTH-1:0]    next_tx_data;
    logic                     next_tx_vld;

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; bytes arriving in wait/transmit states are ignored
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == DATA_WIDTH'(CMD_WR)) begin
                        next_state = ST_WR_ADDR;
                    end else if (RX_P_DATA == DATA_WIDTH'(CMD_RD)) begin
                        next_state = ST_RD_ADDR;
                    end else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_OP)) begin
                        next_state = ST_OPA;
                    end else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_NOP)) begin
                        next_state = ST_FUN;
                    end
                end
            end
            ST_WR_ADDR:  if (RX_D_VLD)     next_state = ST_WR_DATA;
            ST_WR_DATA:  if (RX_D_VLD)     next_state = ST_IDLE;
            ST_RD_ADDR:  if (RX_D_VLD)     next_state = ST_RD_WAIT;
            ST_RD_WAIT:  if (RdData_Valid) next_state = ST_RD_TX;
            ST_RD_TX:    if (!FIFO_FULL)   next_state = ST_IDLE;
            ST_OPA:      if (RX_D_VLD)     next_state = ST_OPB;
            ST_OPB:      if (RX_D_VLD)     next_state = ST_FUN;
            ST_FUN:      if (RX_D_VLD)     next_state = ST_ALU_WAIT;
            ST_ALU_WAIT: if (OUT_Valid)    next_state = ST_TX_LO;
            ST_TX_LO:    if (!FIFO_FULL)   next_state = ST_TX_HI;
            ST_TX_HI:    if (!FIFO_FULL)   next_state = ST_IDLE;
            default:                       next_state = ST_IDLE;
        endcase
    end

    // Output decode: strobes default low, data/address/function hold
    always_comb begin
        next_address = Address;
        next_wr_data = WrData;
        next_wr_en   = 1'b0;
        next_rd_en   = 1'b0;
        next_alu_fun = ALU_FUN;
        next_alu_en  = 1'b0;
        next_tx_data = TX_P_DATA;
        next_tx_vld  = 1'b0;
        case (state)
            ST_WR_ADDR: begin
                if (RX_D_VLD) begin
                    next_address = RX_P_DATA[ADDR_WIDTH-1:0];
                end
            end
            ST_WR_DATA: begin
                if (RX_D_VLD) begin
                    next_wr_data = RX_P_DATA;
                    next_wr_en   = 1'b1;
                end
            end
            ST_RD_ADDR: begin
                if (RX_D_VLD) begin
                    next_address = RX_P_DATA[ADDR_WIDTH-1:0];
                    next_rd_en   = 1'b1;
                end
            end
            ST_RD_TX: begin
                if (!FIFO_FULL) begin
                    next_tx_data = rd_capture;
                    next_tx_vld  = 1'b1;
                end
            end
            ST_OPA: begin
                if (RX_D_VLD) begin
                    next_address = ADDR_WIDTH'(ADDR_OPA);
                    next_wr_data = RX_P_DATA;
                    next_wr_en   = 1'b1;
                end
            end
            ST_OPB: begin
                if (RX_D_VLD) begin
                    next_address = ADDR_WIDTH'(ADDR_OPB);
                    next_wr_data = RX_P_DATA;
                    next_wr_en   = 1'b1;
                end
            end
            ST_FUN: begin
                if (RX_D_VLD) begin
                    next_alu_fun = RX_P_DATA[FUN_WIDTH-1:0];
                    next_alu_en  = 1'b1;
                end
            end
            ST_TX_LO: begin
                if (!FIFO_FULL) begin
                    next_tx_data = alu_result[DATA_WIDTH-1:0];
                    next_tx_vld  = 1'b1;
                end
            end
            ST_TX_HI: begin
                if (!FIFO_FULL) begin
                    next_tx_data = alu_result[ALU_OUT_WIDTH-1:DATA_WIDTH];
                    next_tx_vld  = 1'b1;
                end
            end
            default: begin
                next_tx_vld = 1'b0;
            end
        endcase
        // ALU clock runs for every cycle spent in FUN or ALU_WAIT
        next_clk_en = (next_state == ST_FUN) || (next_state == ST_ALU_WAIT);
    end

    // Output registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Address   <= '0;
            WrData    <= '0;
            WrEn      <= 1'b0;
            RdEn      <= 1'b0;
            ALU_FUN   <= '0;
            ALU_EN    <= 1'b0;
            CLK_EN    <= 1'b0;
            TX_P_DATA <= '0;
            TX_D_VLD  <= 1'b0;
        end else begin
            Address   <= next_address;
            WrData    <= next_wr_data;
            WrEn      <= next_wr_en;
            RdEn      <= next_rd_en;
            ALU_FUN   <= next_alu_fun;
            ALU_EN    <= next_alu_en;
            CLK_EN    <= next_clk_en;
            TX_P_DATA <= next_tx_data;
            TX_D_VLD  <= next_tx_vld;
        end
    end

    // Capture returned read data and ALU result while waiting for them
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_capture <= '0;
            alu_result <= '0;
        end else begin
            if ((state == ST_RD_WAIT) && RdData_Valid) begin
                rd_capture <= RdData;
            end
            if ((state == ST_ALU_WAIT) && OUT_Valid) begin
                alu_result <= ALU_OUT;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sys_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_sys_ctrl
//  Brief    : Self-checking bench for sys_ctrl. Expected register writes,
//             reads, ALU launches and TX bytes are queued by the stimulus as
//             each command completes and consumed by one compare process.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sys_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RX_P_DATA = 8'h00;
    logic        RX_D_VLD = 1'b0;
    logic [7:0]  RdData = 8'h00;
    logic        RdData_Valid = 1'b0;
    logic [15:0] ALU_OUT = 16'h0000;
    logic        OUT_Valid = 1'b0;
    logic        FIFO_FULL = 1'b0;
    logic [3:0]  Address;
    logic [7:0]  WrData;
    logic        WrEn;
    logic        RdEn;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN;
    logic        CLK_EN;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;

    sys_ctrl #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_OUT_WIDTH(16), .FUN_WIDTH(4)
    ) dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RdData(RdData), .RdData_Valid(RdData_Valid),
        .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid), .FIFO_FULL(FIFO_FULL),
        .Address(Address), .WrData(WrData), .WrEn(WrEn), .RdEn(RdEn),
        .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .CLK_EN(CLK_EN),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
    );

    always #5 CLK = ~CLK;

    // Expected transactions
    typedef struct { logic [3:0] addr; logic [7:0] data; int cyc; } wr_t;
    typedef struct { logic [3:0] addr; int cyc; } rd_t;
    typedef struct { logic [3:0] fun; int cyc; } alu_t;
    wr_t        wr_q[$];
    rd_t        rd_q[$];
    alu_t       alu_q[$];
    logic [7:0] tx_q[$];

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic full_at_edge = 1'b0;
    logic chk_on = 1'b0;
    logic exp_clk_en = 1'b0;
    logic [3:0] exp_alu_fun = 4'h0;
    wr_t  we;
    rd_t  re;
    alu_t ae;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge CLK) begin
        cyc          <= cyc + 1;
        full_at_edge <= FIFO_FULL;
    end

    // Compare process: every strobe must match the head of its queue
    always @(negedge CLK) begin
        if (chk_on) begin
            chk("clk_en", {31'b0, CLK_EN}, {31'b0, exp_clk_en});
            chk("alu_fun_hold", {28'b0, ALU_FUN}, {28'b0, exp_alu_fun});
            if (WrEn && RdEn) chk("wr_rd_exclusive", {31'b0, RdEn}, 32'd0);
            if (WrEn) begin
                chk("wr_pending", {31'b0, wr_q.size() != 0}, 32'd1);
                if (wr_q.size() != 0) begin
                    we = wr_q.pop_front();
                    chk("wr_addr", {28'b0, Address}, {28'b0, we.addr});
                    chk("wr_data", {24'b0, WrData}, {24'b0, we.data});
                    chk("wr_latency", cyc, we.cyc);
                end
            end
            if (RdEn) begin
                chk("rd_pending", {31'b0, rd_q.size() != 0}, 32'd1);
                if (rd_q.size() != 0) begin
                    re = rd_q.pop_front();
                    chk("rd_addr", {28'b0, Address}, {28'b0, re.addr});
                    chk("rd_latency", cyc, re.cyc);
                end
            end
            if (ALU_EN) begin
                chk("alu_pending", {31'b0, alu_q.size() != 0}, 32'd1);
                if (alu_q.size() != 0) begin
                    ae = alu_q.pop_front();
                    chk("alu_fun", {28'b0, ALU_FUN}, {28'b0, ae.fun});
                    chk("alu_latency", cyc, ae.cyc);
                end
            end
            if (TX_D_VLD) begin
                chk("tx_pending", {31'b0, tx_q.size() != 0}, 32'd1);
                chk("tx_while_full", {31'b0, full_at_edge}, 32'd0);
                if (tx_q.size() != 0) chk("tx_data", {24'b0, TX_P_DATA}, {24'b0, tx_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        tick();
        RX_D_VLD  = 1'b0;
    endtask

    // Wait until every queued expectation has been observed, bounded
    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((wr_q.size() + rd_q.size() + alu_q.size() + tx_q.size()) != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(name, wr_q.size() + rd_q.size() + alu_q.size() + tx_q.size(), 32'd0);
        wr_q.delete(); rd_q.delete(); alu_q.delete(); tx_q.delete();
    endtask

    task automatic read_flow(input logic [7:0] addr, input logic [7:0] rdata, input string name);
        send(8'hBB);
        send(addr);
        rd_q.push_back('{addr: addr[3:0], cyc: cyc});
        wait_drain({name, "_rden"}, 20);
        send(8'hAA);                       // dropped while waiting for read data
        RdData = rdata;
        RdData_Valid = 1'b1;
        tick();
        RdData_Valid = 1'b0;
        tx_q.push_back(rdata);
        wait_drain({name, "_tx"}, 20);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        chk("reset_outputs", {3'b0, Address, WrData, WrEn, RdEn, ALU_FUN, ALU_EN, CLK_EN, TX_P_DATA, TX_D_VLD}, 32'd0);
        RST = 1'b1;
        chk_on = 1'b1;
        tick();

        // 1: register write
        send(8'hAA); send(8'h05); send(8'h3C);
        wr_q.push_back('{addr: 4'h5, data: 8'h3C, cyc: cyc});
        wait_drain("t1_write", 20);
        chk("t1_addr_hold", {28'b0, Address}, 32'h5);
        chk("t1_data_hold", {24'b0, WrData}, 32'h3C);

        // 2: register read with a stray byte in RD_WAIT
        read_flow(8'h05, 8'h3C, "t2");
        chk("t2_tx_hold", {24'b0, TX_P_DATA}, 32'h3C);

        // 3: ALU with operands
        send(8'hCC);
        send(8'h0A); wr_q.push_back('{addr: 4'h0, data: 8'h0A, cyc: cyc});
        send(8'h14); wr_q.push_back('{addr: 4'h1, data: 8'h14, cyc: cyc});
        exp_clk_en = 1'b1;
        send(8'h00); alu_q.push_back('{fun: 4'h0, cyc: cyc});
        exp_alu_fun = 4'h0;
        wait_drain("t3_launch", 20);
        tick();
        ALU_OUT = 16'h001E; OUT_Valid = 1'b1;
        tick();
        OUT_Valid = 1'b0;
        exp_clk_en = 1'b0;
        tx_q.push_back(8'h1E); tx_q.push_back(8'h00);
        wait_drain("t3_tx", 20);
        chk("t3_tx_last", {24'b0, TX_P_DATA}, 32'h00);

        // 4: ALU without operands, TX stalled by FIFO_FULL
        send(8'hDD);
        exp_clk_en = 1'b1;
        send(8'h02); alu_q.push_back('{fun: 4'h2, cyc: cyc});
        exp_alu_fun = 4'h2;
        wait_drain("t4_launch", 20);
        tick();
        FIFO_FULL = 1'b1;
        ALU_OUT = 16'hBEEF; OUT_Valid = 1'b1;
        tick();
        OUT_Valid = 1'b0;
        exp_clk_en = 1'b0;
        tx_q.push_back(8'hEF); tx_q.push_back(8'hBE);
        repeat (4) tick();
        chk("t4_stall_held", tx_q.size(), 32'd2);
        FIFO_FULL = 1'b0;
        wait_drain("t4_tx", 20);
        chk("t4_tx_last", {24'b0, TX_P_DATA}, 32'hBE);

        // 5: unknown byte ignored, then normal write
        send(8'h55);
        repeat (3) tick();
        send(8'hAA); send(8'h01); send(8'hFF);
        wr_q.push_back('{addr: 4'h1, data: 8'hFF, cyc: cyc});
        wait_drain("t5_write", 20);

        // 6: reset during OPB aborts the command
        send(8'hCC);
        send(8'h0A); wr_q.push_back('{addr: 4'h0, data: 8'h0A, cyc: cyc});
        wait_drain("t6_opa", 20);
        RST = 1'b0;
        exp_alu_fun = 4'h0;
        exp_clk_en = 1'b0;
        tick(); tick();
        chk("t6_reset_outputs", {3'b0, Address, WrData, WrEn, RdEn, ALU_FUN, ALU_EN, CLK_EN, TX_P_DATA, TX_D_VLD}, 32'd0);
        RST = 1'b1;
        tick();
        read_flow(8'h03, 8'h5A, "t6");

        // 7: address wrap to ADDR_WIDTH bits
        send(8'hAA); send(8'h1F); send(8'h77);
        wr_q.push_back('{addr: 4'hF, data: 8'h77, cyc: cyc});
        wait_drain("t7_write", 20);
        chk("t7_addr_wrap", {28'b0, Address}, 32'hF);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
